multi_debouncer: RTL and testbench

Parametrised N-channel pushbutton debouncer with per-channel polarity, input synchronisation and glitch abort. Each channel produces a debounced level, one-cycle press and release pulses, and a one-shot long-press pulse. It sits between the board pushbutton pins and user-control logic such as menu FSMs or mode selectors, and drives all channels from one clock domain.

---
 rtl/multi_debouncer.sv | 150 +++++++++++++++
 tb/tb_multi_debouncer.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/multi_debouncer.sv
// rtl/multi_debouncer.sv - N-channel pushbutton debouncer with polarity, sync, glitch abort and long-press
//
// Ports:
//   clk            system clock
//   n_rst          synchronous active-low reset
//   active_low     per-channel polarity (1 = pressed reads 0 on button_in)
//   button_in      raw asynchronous button pins
//   button_out     debounced level, active-high, registered
//   press_pulse    one-cycle pulse on committed press
//   release_pulse  one-cycle pulse on committed release
//   long_press     one-cycle pulse once per press after the hold time
//   any_pressed    OR of button_out
module multi_debouncer #(
    parameter int NUM_CH         = 4,
    parameter int CLK_PERIOD_NS  = 20,
    parameter int BOUNCE_TIME_MS = 20,
    parameter int LONG_PRESS_MS  = 1000,
    parameter int SIM_FAST       = 0
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic [NUM_CH-1:0] active_low,
    input  logic [NUM_CH-1:0] button_in,
    output logic [NUM_CH-1:0] button_out,
    output logic [NUM_CH-1:0] press_pulse,
    output logic [NUM_CH-1:0] release_pulse,
    output logic [NUM_CH-1:0] long_press,
    output logic              any_pressed
);

    localparam longint TIME_SCALE = (SIM_FAST != 0) ? longint'(CLK_PERIOD_NS) : 64'd1_000_000;
    localparam longint CNT_MAX    = longint'(BOUNCE_TIME_MS) * TIME_SCALE / longint'(CLK_PERIOD_NS);
    localparam longint LP_MAX     = longint'(LONG_PRESS_MS) * TIME_SCALE / longint'(CLK_PERIOD_NS);
    localparam int     CNT_W      = $clog2(CNT_MAX + 1);
    localparam int     LP_W       = $clog2(LP_MAX + 1);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX - 1);
    localparam logic [LP_W-1:0]  LP_LAST  = LP_W'(LP_MAX - 1);

    typedef enum logic [1:0] {
        RELEASED     = 2'd0,
        PUSH_WAIT    = 2'd1,
        PUSHED       = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [1:0]       sync;
        logic             btn;
        state_t           state, state_nx;
        logic [CNT_W-1:0] cnt, cnt_nx;
        logic [LP_W-1:0]  hold, hold_nx;
        logic             fired, fired_nx;
        logic             out_q, out_nx;
        logic             press_q, press_nx;
        logic             release_q, release_nx;
        logic             lp_q, lp_nx;

        assign btn = sync[1];

        always_ff @(posedge clk) begin
            if (!n_rst) begin
                sync      <= 2'b00;
                state     <= RELEASED;
                cnt       <= '0;
                hold      <= '0;
                fired     <= 1'b0;
                out_q     <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
                lp_q      <= 1'b0;
            end else begin
                // Polarity is folded in before the synchroniser so a runtime
                // polarity flip is debounced like any other input change.
                sync      <= {sync[0], button_in[i] ^ active_low[i]};
                state     <= state_nx;
                cnt       <= cnt_nx;
                hold      <= hold_nx;
                fired     <= fired_nx;
                out_q     <= out_nx;
                press_q   <= press_nx;
                release_q <= release_nx;
                lp_q      <= lp_nx;
            end
        end

        always_comb begin
            state_nx   = state;
            cnt_nx     = '0;
            hold_nx    = hold;
            fired_nx   = fired;
            press_nx   = 1'b0;
            release_nx = 1'b0;
            lp_nx      = 1'b0;
            case (state)
                RELEASED: begin
                    hold_nx  = '0;
                    fired_nx = 1'b0;
                    if (btn) state_nx = PUSH_WAIT;
                end
                PUSH_WAIT: begin
                    hold_nx = '0;
                    if (!btn) begin
                        state_nx = RELEASED;
                    end else if (cnt == CNT_LAST) begin
                        state_nx = PUSHED;
                        press_nx = 1'b1;
                    end else begin
                        cnt_nx = cnt + 1'b1;
                    end
                end
                PUSHED: begin
                    if (!btn) state_nx = RELEASE_WAIT;
                    if (hold != LP_LAST) hold_nx = hold + 1'b1;
                    // The fired flag keeps the saturated hold counter from
                    // re-triggering until the channel is released.
                    if (hold == LP_LAST && !fired) begin
                        lp_nx    = 1'b1;
                        fired_nx = 1'b1;
                    end
                end
                RELEASE_WAIT: begin
                    // hold is left untouched so an aborted release resumes counting
                    if (btn) begin
                        state_nx = PUSHED;
                    end else if (cnt == CNT_LAST) begin
                        state_nx   = RELEASED;
                        release_nx = 1'b1;
                    end else begin
                        cnt_nx = cnt + 1'b1;
                    end
                end
                default: begin
                    state_nx = RELEASED;
                    hold_nx  = '0;
                    fired_nx = 1'b0;
                end
            endcase
            out_nx = (state_nx == PUSHED) || (state_nx == RELEASE_WAIT);
        end

        assign button_out[i]    = out_q;
        assign press_pulse[i]   = press_q;
        assign release_pulse[i] = release_q;
        assign long_press[i]    = lp_q;
    end

    assign any_pressed = |button_out;

endmodule

// File: tb/tb_multi_debouncer.sv
// tb/tb_multi_debouncer.sv - directed self-checking bench for multi_debouncer
module tb_multi_debouncer;

    logic       clk = 1'b0;
    logic       n_rst;
    logic [3:0] active_low;
    logic [3:0] button_in;
    logic [3:0] button_out;
    logic [3:0] press_pulse;
    logic [3:0] release_pulse;
    logic [3:0] long_press;
    logic       any_pressed;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int press_cnt[4], press_cyc[4];
    int release_cnt[4], release_cyc[4];
    int lp_cnt[4], lp_cyc[4];
    int t0, p;

    multi_debouncer #(
        .NUM_CH(4), .CLK_PERIOD_NS(20), .BOUNCE_TIME_MS(8),
        .LONG_PRESS_MS(40), .SIM_FAST(1)
    ) dut (
        .clk(clk), .n_rst(n_rst), .active_low(active_low), .button_in(button_in),
        .button_out(button_out), .press_pulse(press_pulse), .release_pulse(release_pulse),
        .long_press(long_press), .any_pressed(any_pressed)
    );

    always #10 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic clr_counts();
        for (int c = 0; c < 4; c++) begin
            press_cnt[c] = 0; press_cyc[c] = -1;
            release_cnt[c] = 0; release_cyc[c] = -1;
            lp_cnt[c] = 0; lp_cyc[c] = -1;
        end
    endtask

    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            cyc++;
            for (int c = 0; c < 4; c++) begin
                if (press_pulse[c])   begin press_cnt[c]++;   press_cyc[c] = cyc;   end
                if (release_pulse[c]) begin release_cnt[c]++; release_cyc[c] = cyc; end
                if (long_press[c])    begin lp_cnt[c]++;      lp_cyc[c] = cyc;      end
            end
        end
    endtask

    initial begin
        n_rst      = 1'b0;
        active_low = 4'b0010;
        button_in  = 4'b0010;
        clr_counts();

        // reset state
        step(3);
        check("rst_button_out", int'(button_out), 0);
        check("rst_pulses", int'({press_pulse, release_pulse, long_press}), 0);
        check("rst_any", int'(any_pressed), 0);
        n_rst = 1'b1;
        step(3);

        // 1. clean press and release
        clr_counts();
        t0 = cyc;
        button_in[0] = 1'b1;
        step(10);
        check("t1_out_early", int'(button_out[0]), 0);
        step(1);
        check("t1_out_rise", int'(button_out[0]), 1);
        check("t1_press_at_11", int'(press_pulse[0]), 1);
        step(1);
        check("t1_press_1cyc", int'(press_pulse[0]), 0);
        t0 = cyc;
        button_in[0] = 1'b0;
        step(12);
        check("t1_release_lat", release_cyc[0] - t0, 11);
        check("t1_release_cnt", release_cnt[0], 1);
        check("t1_out_fall", int'(button_out[0]), 0);

        // 2. bounce
        clr_counts();
        for (int i = 0; i < 8; i++) begin
            button_in[0] = (i % 2 == 0);
            step(3);
        end
        check("t2_quiet_press", press_cnt[0], 0);
        check("t2_quiet_out", int'(button_out[0]), 0);
        t0 = cyc;
        button_in[0] = 1'b1;
        step(11);
        check("t2_press_cnt", press_cnt[0], 1);
        check("t2_press_lat", press_cyc[0] - t0, 11);

        // 3. glitch abort while pushed, then while released
        button_in[0] = 1'b0;
        step(5);
        button_in[0] = 1'b1;
        step(12);
        check("t3_hold_out", int'(button_out[0]), 1);
        check("t3_no_release", release_cnt[0], 0);
        check("t3_no_lp", lp_cnt[0], 0);
        button_in[0] = 1'b0;
        step(12);
        check("t3_release", release_cnt[0], 1);
        clr_counts();
        button_in[0] = 1'b1;
        step(5);
        button_in[0] = 1'b0;
        step(12);
        check("t3_no_press", press_cnt[0], 0);
        check("t3_rel_out", int'(button_out[0]), 0);

        // 4. long press, plain then with a 4-cycle release glitch
        clr_counts();
        button_in[0] = 1'b1;
        step(11);
        p = press_cyc[0];
        step(60);
        check("t4_lp_cnt", lp_cnt[0], 1);
        check("t4_lp_lat", lp_cyc[0] - p, 40);
        button_in[0] = 1'b0;
        step(12);
        clr_counts();
        button_in[0] = 1'b1;
        step(11);
        p = press_cyc[0];
        step(19);
        button_in[0] = 1'b0;
        step(4);
        button_in[0] = 1'b1;
        step(60);
        check("t4g_lp_cnt", lp_cnt[0], 1);
        check("t4g_lp_lat", lp_cyc[0] - p, 44);
        check("t4g_no_release", release_cnt[0], 0);
        button_in[0] = 1'b0;
        step(12);

        // 5. polarity and independence
        clr_counts();
        step(20);
        check("t5_idle_ch1", press_cnt[1], 0);
        check("t5_idle_out", int'(button_out), 0);
        t0 = cyc;
        button_in[1] = 1'b0;
        button_in[2] = 1'b1;
        step(11);
        check("t5_ch1_lat", press_cyc[1] - t0, 11);
        check("t5_ch2_lat", press_cyc[2] - t0, 11);
        check("t5_pulses", int'(press_pulse), 4'b0110);
        check("t5_any", int'(any_pressed), 1);
        button_in[1] = 1'b1;
        button_in[2] = 1'b0;
        step(12);
        check("t5_released", int'(button_out), 0);

        // 6. reset mid PUSH_WAIT (ch0) and mid PUSHED (ch3)
        button_in[3] = 1'b1;
        step(11);
        check("t6_ch3_pushed", int'(button_out[3]), 1);
        button_in[0] = 1'b1;
        step(6);
        clr_counts();
        n_rst = 1'b0;
        step(1);
        check("t6_rst_out", int'(button_out), 0);
        check("t6_rst_pulses", int'({press_pulse, release_pulse, long_press}), 0);
        check("t6_rst_any", int'(any_pressed), 0);
        n_rst = 1'b1;
        t0 = cyc;
        step(11);
        check("t6_ch0_lat", press_cyc[0] - t0, 11);
        check("t6_ch3_lat", press_cyc[3] - t0, 11);
        check("t6_press_cnt", press_cnt[0] + press_cnt[3], 2);
        check("t6_no_release", release_cnt[3], 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
